// File: rtl/e_clkgen_ws.sv
`timescale 1ns/1ps
// e_clkgen_ws: 6809E quadrature clock generator (QX/EX from CLKX4) that stretches
// the E-high phase for I/O-window accesses and MRDY requests, capped by MAX_STRETCH.
module e_clkgen_ws #(
   parameter int unsigned PHASE_LEN   = 1,
   parameter logic [15:0] IO_ADDR_MIN = 16'hFC00,
   parameter logic [15:0] IO_ADDR_MAX = 16'hFEFF,
   parameter int unsigned IO_WAIT     = 1,
   parameter int unsigned MAX_STRETCH = 15
) (
   input  logic        CLKX4,
   input  logic        nRESET,
   input  logic [15:0] ADDR,
   input  logic        BA,
   input  logic        MRDY,
   output logic        QX,
   output logic        EX,
   output logic        STRETCH,
   output logic        TIMEOUT
);

   // Encoding places QX, EX and STRETCH on individual state flops: {STRETCH, EX, QX}.
   typedef enum logic [2:0] {
      S0 = 3'b000,
      S1 = 3'b001,
      S2 = 3'b011,
      S3 = 3'b010,
      SX = 3'b110
   } state_t;

   localparam logic [3:0] C_QLAST       = 4'(PHASE_LEN - 1);
   localparam logic [3:0] C_IO_WAIT     = 4'(IO_WAIT);
   localparam logic [3:0] C_MAX_STRETCH = 4'(MAX_STRETCH);

   state_t     r_state, w_state_nxt;
   logic [3:0] r_qcnt, w_qcnt_nxt;
   logic [3:0] r_wait, w_wait_nxt;
   logic [3:0] r_scnt, w_scnt_nxt;
   logic       r_timeout, w_timeout_nxt;
   logic       w_qend;
   logic       w_in_window;
   logic       w_req;

   assign w_qend      = (r_qcnt == C_QLAST);
   assign w_in_window = (ADDR >= IO_ADDR_MIN) && (ADDR <= IO_ADDR_MAX) && !BA;
   assign w_req       = (r_wait != 4'd0) || !MRDY;

   // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLKX4 or negedge nRESET) begin
      if (!nRESET) begin
         r_state   <= S0;
         r_qcnt    <= 4'd0;
         r_wait    <= 4'd0;
         r_scnt    <= 4'd0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_qcnt    <= w_qcnt_nxt;
         r_wait    <= w_wait_nxt;
         r_scnt    <= w_scnt_nxt;
         r_timeout <= w_timeout_nxt;
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no latch can be inferred.
      w_state_nxt   = r_state;
      w_qcnt_nxt    = r_qcnt + 4'd1;
      w_wait_nxt    = r_wait;
      w_scnt_nxt    = r_scnt;
      w_timeout_nxt = 1'b0;

      if (w_qend) begin
         w_qcnt_nxt = 4'd0;
         case (r_state)
            S0: w_state_nxt = S1;
            S1: begin
               w_state_nxt = S2;
               w_wait_nxt  = w_in_window ? C_IO_WAIT : 4'd0;
               w_scnt_nxt  = 4'd0;
            end
            S2: w_state_nxt = S3;
            S3, SX: begin
               // I/O wait and MRDY overlap: either one keeps E high for another quarter.
               if (w_req && (r_scnt < C_MAX_STRETCH)) begin
                  w_state_nxt = SX;
                  w_scnt_nxt  = r_scnt + 4'd1;
                  if (r_wait != 4'd0) begin
                     w_wait_nxt = r_wait - 4'd1;
                  end
               end else begin
                  w_state_nxt   = S0;
                  w_timeout_nxt = w_req;
               end
            end
            default: w_state_nxt = S0;
         endcase
      end
   end

   assign QX      = r_state[0];
   assign EX      = r_state[1];
   assign STRETCH = r_state[2];
   assign TIMEOUT = r_timeout;

endmodule

// File: tb/tb_e_clkgen_ws.sv
`timescale 1ns/1ps
// Bench for e_clkgen_ws: per-CLKX4 expected {QX,EX,STRETCH,TIMEOUT} steps are queued
// with their stimulus and compared as the clock generator produces them.
module tb_e_clkgen_ws;

   localparam logic [3:0] O_S0 = 4'b0000;
   localparam logic [3:0] O_S1 = 4'b1000;
   localparam logic [3:0] O_S2 = 4'b1100;
   localparam logic [3:0] O_S3 = 4'b0100;
   localparam logic [3:0] O_SX = 4'b0110;
   localparam logic [3:0] O_TO = 4'b0001;

   logic        clkx4 = 1'b0;
   logic        n_reset;
   logic        n_reset2;
   logic [15:0] addr;
   logic        ba;
   logic        mrdy;
   logic        qx1, ex1, st1, to1;
   logic        qx2, ex2, st2, to2;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [15:0] addr;
      logic        ba;
      logic        mrdy;
      logic [3:0]  out;
   } step_t;

   step_t sb_q[$];

   always #5 clkx4 = ~clkx4;

   e_clkgen_ws dut1 (
      .CLKX4(clkx4), .nRESET(n_reset), .ADDR(addr), .BA(ba), .MRDY(mrdy),
      .QX(qx1), .EX(ex1), .STRETCH(st1), .TIMEOUT(to1)
   );

   e_clkgen_ws #(.PHASE_LEN(2)) dut2 (
      .CLKX4(clkx4), .nRESET(n_reset2), .ADDR(addr), .BA(ba), .MRDY(mrdy),
      .QX(qx2), .EX(ex2), .STRETCH(st2), .TIMEOUT(to2)
   );

   task automatic push_step(logic [15:0] a, logic b, logic m, logic [3:0] o);
      step_t s;
      s.addr = a;
      s.ba   = b;
      s.mrdy = m;
      s.out  = o;
      sb_q.push_back(s);
   endtask

   // One bus cycle from S0: n_sx stretch quarters, TIMEOUT on entry to S0 if to0,
   // MRDY low for the first n_low sampled quarters (S3 is quarter 0).
   task automatic push_cycle(int plen, logic [15:0] a, logic b, int n_sx, bit to0, int n_low);
      logic pre;
      pre = (n_low > 0) ? 1'b0 : 1'b1;
      for (int r = 0; r < plen; r++) push_step(a, b, pre, (to0 && r == 0) ? (O_S0 | O_TO) : O_S0);
      for (int r = 0; r < plen; r++) push_step(a, b, pre, O_S1);
      for (int r = 0; r < plen; r++) push_step(a, b, pre, O_S2);
      for (int k = 0; k <= n_sx; k++) begin
         for (int r = 0; r < plen; r++) begin
            push_step(a, b, (k < n_low) ? 1'b0 : 1'b1, (k == 0) ? O_S3 : O_SX);
         end
      end
   endtask

   task automatic pop_step(output logic [3:0] o1, output logic [3:0] o2, output logic [3:0] e);
      step_t s;
      s = sb_q.pop_front();
      @(negedge clkx4);
      addr = s.addr;
      ba   = s.ba;
      mrdy = s.mrdy;
      #1;
      o1 = {qx1, ex1, st1, to1};
      o2 = {qx2, ex2, st2, to2};
      e  = s.out;
   endtask

   task automatic test_reset();
      logic [3:0] o1, o2, e;
      int i;
      n_reset  = 1'b0;
      n_reset2 = 1'b0;
      repeat (3) begin
         @(posedge clkx4);
         @(negedge clkx4);
         checks += 2;
         if ({qx1, ex1, st1, to1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold dut1: got %b expected 0000", {qx1, ex1, st1, to1});
         end
         if ({qx2, ex2, st2, to2} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold dut2: got %b expected 0000", {qx2, ex2, st2, to2});
         end
      end
      @(posedge clkx4);
      #1 n_reset = 1'b1;
      push_cycle(1, 16'h0000, 1'b0, 0, 1'b0, 0);
      push_cycle(1, 16'h0000, 1'b0, 0, 1'b0, 0);
      i = 0;
      while (sb_q.size() != 0) begin
         pop_step(o1, o2, e);
         checks++;
         if (o1 !== e) begin
            errors++;
            $display("FAIL reset_release[%0d]: got QX,EX,STRETCH,TIMEOUT=%b expected %b", i, o1, e);
         end
         i++;
         @(posedge clkx4);
      end
   endtask

   task automatic test_io_wait();
      logic [3:0] o1, o2, e;
      int i;
      push_cycle(1, 16'hFE00, 1'b0, 1, 1'b0, 0);
      push_cycle(1, 16'hFF00, 1'b0, 0, 1'b0, 0);
      i = 0;
      while (sb_q.size() != 0) begin
         pop_step(o1, o2, e);
         checks++;
         if (o1 !== e) begin
            errors++;
            $display("FAIL io_wait[%0d]: got QX,EX,STRETCH,TIMEOUT=%b expected %b", i, o1, e);
         end
         i++;
         @(posedge clkx4);
      end
   endtask

   task automatic test_ba_boundary();
      logic [3:0] o1, o2, e;
      int i;
      push_cycle(1, 16'hFC00, 1'b1, 0, 1'b0, 0);
      push_cycle(1, 16'hFBFF, 1'b0, 0, 1'b0, 0);
      push_cycle(1, 16'hFEFF, 1'b0, 1, 1'b0, 0);
      push_cycle(1, 16'hFC00, 1'b0, 1, 1'b0, 0);
      i = 0;
      while (sb_q.size() != 0) begin
         pop_step(o1, o2, e);
         checks++;
         if (o1 !== e) begin
            errors++;
            $display("FAIL ba_boundary[%0d]: got QX,EX,STRETCH,TIMEOUT=%b expected %b", i, o1, e);
         end
         i++;
         @(posedge clkx4);
      end
   endtask

   task automatic test_mrdy();
      logic [3:0] o1, o2, e;
      int i;
      push_cycle(1, 16'h0000, 1'b0, 3, 1'b0, 3);
      push_cycle(1, 16'hFE00, 1'b0, 3, 1'b0, 3);
      push_cycle(1, 16'h0000, 1'b0, 0, 1'b0, 0);
      i = 0;
      while (sb_q.size() != 0) begin
         pop_step(o1, o2, e);
         checks++;
         if (o1 !== e) begin
            errors++;
            $display("FAIL mrdy_stretch[%0d]: got QX,EX,STRETCH,TIMEOUT=%b expected %b", i, o1, e);
         end
         i++;
         @(posedge clkx4);
      end
   endtask

   task automatic test_timeout();
      logic [3:0] o1, o2, e;
      int i;
      push_cycle(1, 16'h0000, 1'b0, 15, 1'b0, 16);
      push_cycle(1, 16'h0000, 1'b0, 15, 1'b1, 16);
      push_cycle(1, 16'h0000, 1'b0, 0, 1'b1, 0);
      push_cycle(1, 16'h0000, 1'b0, 0, 1'b0, 0);
      i = 0;
      while (sb_q.size() != 0) begin
         pop_step(o1, o2, e);
         checks++;
         if (o1 !== e) begin
            errors++;
            $display("FAIL timeout[%0d]: got QX,EX,STRETCH,TIMEOUT=%b expected %b", i, o1, e);
         end
         i++;
         @(posedge clkx4);
      end
   endtask

   task automatic test_phase2_reset();
      logic [3:0] o1, o2, e;
      int i;
      #1 n_reset2 = 1'b1;
      push_cycle(2, 16'h0000, 1'b0, 0, 1'b0, 0);
      push_cycle(2, 16'h0000, 1'b0, 1, 1'b0, 1);
      void'(sb_q.pop_back());
      i = 0;
      while (sb_q.size() != 0) begin
         pop_step(o1, o2, e);
         checks++;
         if (o2 !== e) begin
            errors++;
            $display("FAIL phase2[%0d]: got QX,EX,STRETCH,TIMEOUT=%b expected %b", i, o2, e);
         end
         i++;
         @(posedge clkx4);
      end
      // Second CLKX4 cycle of the SX quarter: still stretching, then reset lands mid-cycle.
      #1;
      checks++;
      if ({qx2, ex2, st2, to2} !== O_SX) begin
         errors++;
         $display("FAIL phase2_in_sx: got %b expected %b", {qx2, ex2, st2, to2}, O_SX);
      end
      #1 n_reset2 = 1'b0;
      #1;
      checks++;
      if ({qx2, ex2, st2, to2} !== 4'b0000) begin
         errors++;
         $display("FAIL phase2_async_reset: got %b expected 0000", {qx2, ex2, st2, to2});
      end
      mrdy = 1'b1;
      @(posedge clkx4);
      @(posedge clkx4);
      #1;
      checks++;
      if ({qx2, ex2, st2, to2} !== 4'b0000) begin
         errors++;
         $display("FAIL phase2_reset_hold: got %b expected 0000", {qx2, ex2, st2, to2});
      end
      n_reset2 = 1'b1;
      push_cycle(2, 16'h0000, 1'b0, 0, 1'b0, 0);
      i = 0;
      while (sb_q.size() != 0) begin
         pop_step(o1, o2, e);
         checks++;
         if (o2 !== e) begin
            errors++;
            $display("FAIL phase2_restart[%0d]: got QX,EX,STRETCH,TIMEOUT=%b expected %b", i, o2, e);
         end
         i++;
         @(posedge clkx4);
      end
   endtask

   initial begin
      n_reset  = 1'b0;
      n_reset2 = 1'b0;
      addr     = 16'h0000;
      ba       = 1'b0;
      mrdy     = 1'b1;
      test_reset();
      test_io_wait();
      test_ba_boundary();
      test_mrdy();
      test_timeout();
      test_phase2_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/e_clkgen_ws.md
Name: e_clkgen_ws

Overview:
- Parametrised successor to the CPLD's fixed 6809E clock generator. Produces quadrature QX/EX from CLKX4.
- Stretches the E-high phase in two cases: automatically for accesses inside a configurable I/O window, and on demand from MRDY. A timeout cap applies to MRDY stretching.
- Sits beside the address decoder in the MMU CPLD, drives the 6809E clock pins, and reports stretch and timeout status.

Parameters:
- PHASE_LEN, 1, CLKX4 cycles per quarter phase (1..8).
- IO_ADDR_MIN, 16'hFC00, lowest address that receives automatic wait states.
- IO_ADDR_MAX, 16'hFEFF, highest address that receives automatic wait states.
- IO_WAIT, 1, extra quarter phases inserted in E-high for I/O-window accesses (0..15).
- MAX_STRETCH, 15, cap on total inserted quarter phases per bus cycle (1..15).

Ports:
- CLKX4  in  1  master clock, 4x E at PHASE_LEN=1; all logic on its rising edge.
- nRESET  in  1  asynchronous, active-low reset.
- ADDR  in  16  CPU address, valid from QX rise.
- BA  in  1  bus available; 1 suppresses automatic I/O wait states.
- MRDY  in  1  memory ready; 0 requests a stretch.
- QX  out  1  quadrature clock to the CPU.
- EX  out  1  E clock to the CPU.
- STRETCH  out  1  high while the current E-high phase is being extended.
- TIMEOUT  out  1  one-CLKX4 pulse when a stretch is terminated by MAX_STRETCH.

Behaviour:
- Reset (async, nRESET=0): state=S0, quarter counter=0, wait counter=0, stretch counter=0; QX=0, EX=0, STRETCH=0, TIMEOUT=0. Reset mid-stretch aborts immediately. After nRESET deasserts, the first edge starts a fresh S0.
- States and outputs; QX and EX are registered and decoded from the state register with no combinational path from inputs:
  - S0: EX=0, QX=0.
  - S1: EX=0, QX=1.
  - S2: EX=1, QX=1.
  - S3: EX=1, QX=0.
  - SX (stretch): EX=1, QX=0, STRETCH=1.
- Quarter counter counts 0..PHASE_LEN-1 in every state. A state is left only on the CLKX4 edge where the counter is PHASE_LEN-1; the counter then resets to 0.
- Fixed transitions: S0->S1, S1->S2, S2->S3.
- On the S1->S2 edge, load the wait counter with IO_WAIT if IO_ADDR_MIN<=ADDR<=IO_ADDR_MAX and BA=0, else 0. Clear the stretch counter.
- Exit from S3 or SX at end of quarter:
  - If wait counter>0 or MRDY=0, and stretch counter<MAX_STRETCH: go to SX, decrement the wait counter if >0 (saturating at 0), increment the stretch counter.
  - If a stretch is still requested but stretch counter=MAX_STRETCH: go to S0 and pulse TIMEOUT for one CLKX4 cycle.
  - Otherwise go to S0.
- MRDY is sampled only on the last CLKX4 cycle of each S3/SX quarter. It must meet setup to CLKX4; it is not synchronised internally.
- I/O wait states and MRDY stretch overlap, they do not add: SX is entered while either is active.
- Stretch granularity is one quarter (PHASE_LEN CLKX4 cycles), which keeps EX/QX edges aligned to the quarter grid.
- Timing at PHASE_LEN=1: unstretched period is 4 CLKX4 cycles (EX high 2, QX high 2). Each stretch quarter adds 1 cycle to EX high and to the period. QX high width never changes.
- Falling QX always precedes falling EX by PHASE_LEN*(1+stretch count) cycles.
- Counters are 4 bits and saturate; no wrap-around.
- STRETCH is 1 exactly while in SX. TIMEOUT is asserted on the same edge that enters S0 from a capped stretch.

Test Plan:
- Reset: hold nRESET=0 across 3 CLKX4 edges, then release with MRDY=1, ADDR=16'h0000, PHASE_LEN=1 -> QX=EX=0 during reset. EX pattern then repeats 0,0,1,1 and QX 0,1,1,0 with period 4.
- I/O wait: ADDR=16'hFE00, BA=0, IO_WAIT=1 -> EX high 3 cycles, one SX cycle with STRETCH=1, period 5. Same with ADDR=16'hFF00 -> period 4.
- BA suppression: ADDR=16'hFC00, BA=1 -> no stretch, period 4. Boundary checks: ADDR=16'hFBFF and 16'hFEFF -> no stretch and stretch respectively.
- MRDY stretch: MRDY=0 for 3 sampled quarters, ADDR outside the window -> 3 SX cycles, EX high 5 cycles, no TIMEOUT. Overlapped with an I/O access (IO_WAIT=1) -> still 3 SX cycles.
- Timeout: MRDY held 0 with MAX_STRETCH=15 -> exactly 15 SX cycles, then S0 with a one-cycle TIMEOUT=1. The next cycle stretches again while MRDY stays 0.
- PHASE_LEN=2 with a mid-SX reset: normal period 8 with EX high 4. Assert nRESET=0 during SX -> EX, QX and STRETCH drop asynchronously, and the cycle restarts in S0 after release.
